// File: rtl/vec_alu_seq_pkg.sv
// Shared definitions for the vector ALU sequencer: ALU op codes, FSM states
// and op classification helpers.
package vec_alu_seq_pkg;

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ADD   = 4'b0000;
    localparam logic [OP_W-1:0] OP_SUB   = 4'b0001;
    localparam logic [OP_W-1:0] OP_AND   = 4'b0010;
    localparam logic [OP_W-1:0] OP_OR    = 4'b0011;
    localparam logic [OP_W-1:0] OP_LSL   = 4'b0100;
    localparam logic [OP_W-1:0] OP_CMP   = 4'b0101;
    localparam logic [OP_W-1:0] OP_STALL = 4'b1100;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_EXEC  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } seq_state_t;

    // Ops ADD..CMP are the only ones the sequencer will run.
    function automatic logic is_legal_op(input logic [OP_W-1:0] op);
        return (op <= OP_CMP);
    endfunction

    // CMP only updates flags; every other legal op stores its result.
    function automatic logic op_writes_back(input logic [OP_W-1:0] op);
        return (op <= OP_LSL);
    endfunction

endpackage

// File: rtl/vec_alu_sequencer.sv
// Walks a vector of operand pairs through the scalar ALU: read A/B, execute,
// write back (skipped for CMP), then report completion and aggregate flags.
module vec_alu_sequencer
    import vec_alu_seq_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned LEN_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_src_a,
    input  logic [ADDR_W-1:0] cmd_src_b,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_rd_addr_a,
    output logic [ADDR_W-1:0] mem_rd_addr_b,
    input  logic [DATA_W-1:0] mem_rd_data_a,
    input  logic [DATA_W-1:0] mem_rd_data_b,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zero,
    input  logic              alu_negative,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              all_zero,
    output logic              any_neg
);

    seq_state_t          r_state, w_state_nxt;

    logic [OP_W-1:0]     r_op,     w_op_nxt;
    logic [ADDR_W-1:0]   r_src_a,  w_src_a_nxt;
    logic [ADDR_W-1:0]   r_src_b,  w_src_b_nxt;
    logic [ADDR_W-1:0]   r_dst,    w_dst_nxt;
    logic [LEN_W-1:0]    r_len,    w_len_nxt;
    logic [LEN_W-1:0]    r_i,      w_i_nxt;
    logic [DATA_W-1:0]   r_result, w_result_nxt;

    logic                w_accept;
    logic                w_last;

    logic                r_cmd_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_mem_rd_en;
    logic [ADDR_W-1:0]   r_mem_rd_addr_a;
    logic [ADDR_W-1:0]   r_mem_rd_addr_b;
    logic                r_mem_wr_en;
    logic [ADDR_W-1:0]   r_mem_wr_addr;
    logic [DATA_W-1:0]   r_mem_wr_data;
    logic [3:0]          r_alu_sel;
    logic                r_err;
    logic                r_all_zero;
    logic                r_any_neg;

    logic [DATA_W-1:0]   w_alu_a;
    logic [DATA_W-1:0]   w_alu_b;

    assign w_accept = cmd_valid && (r_state == S_IDLE);
    assign w_last   = (r_i == LEN_W'(r_len - LEN_W'(1)));

    // Read data only arrives in EXEC, so the operand path is a gated pass-through.
    assign w_alu_a = (r_state == S_EXEC) ? mem_rd_data_a : '0;
    assign w_alu_b = (r_state == S_EXEC) ? mem_rd_data_b : '0;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, command latch, element index and result capture.
    always_comb begin
        w_state_nxt  = r_state;
        w_op_nxt     = r_op;
        w_src_a_nxt  = r_src_a;
        w_src_b_nxt  = r_src_b;
        w_dst_nxt    = r_dst;
        w_len_nxt    = r_len;
        w_i_nxt      = r_i;
        w_result_nxt = r_result;

        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_op_nxt    = cmd_op;
                    w_src_a_nxt = cmd_src_a;
                    w_src_b_nxt = cmd_src_b;
                    w_dst_nxt   = cmd_dst;
                    w_len_nxt   = cmd_len;
                    w_i_nxt     = '0;
                    if (is_legal_op(cmd_op) && (cmd_len != '0)) begin
                        w_state_nxt = S_READ;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_READ: begin
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                w_result_nxt = alu_out;
                if (op_writes_back(r_op)) begin
                    w_state_nxt = S_WRITE;
                end else if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_i_nxt     = LEN_W'(r_i + LEN_W'(1));
                    w_state_nxt = S_READ;
                end
            end
            S_WRITE: begin
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_i_nxt     = LEN_W'(r_i + LEN_W'(1));
                    w_state_nxt = S_READ;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Command context, element index and captured result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op     <= OP_STALL;
            r_src_a  <= '0;
            r_src_b  <= '0;
            r_dst    <= '0;
            r_len    <= '0;
            r_i      <= '0;
            r_result <= '0;
        end else begin
            r_op     <= w_op_nxt;
            r_src_a  <= w_src_a_nxt;
            r_src_b  <= w_src_b_nxt;
            r_dst    <= w_dst_nxt;
            r_len    <= w_len_nxt;
            r_i      <= w_i_nxt;
            r_result <= w_result_nxt;
        end
    end

    // Strobes, addresses and status decoded from the upcoming state and registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_ready     <= 1'b1;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_mem_rd_en     <= 1'b0;
            r_mem_rd_addr_a <= '0;
            r_mem_rd_addr_b <= '0;
            r_mem_wr_en     <= 1'b0;
            r_mem_wr_addr   <= '0;
            r_mem_wr_data   <= '0;
            r_alu_sel       <= OP_STALL;
        end else begin
            r_cmd_ready <= (w_state_nxt == S_IDLE);
            r_busy      <= (w_state_nxt == S_READ) || (w_state_nxt == S_EXEC) ||
                           (w_state_nxt == S_WRITE);
            r_done      <= (w_state_nxt == S_DONE);
            r_mem_rd_en <= (w_state_nxt == S_READ);
            r_mem_wr_en <= (w_state_nxt == S_WRITE);
            r_alu_sel   <= (w_state_nxt == S_EXEC) ? w_op_nxt : OP_STALL;

            if (w_state_nxt == S_READ) begin
                r_mem_rd_addr_a <= ADDR_W'(w_src_a_nxt + ADDR_W'(w_i_nxt));
                r_mem_rd_addr_b <= ADDR_W'(w_src_b_nxt + ADDR_W'(w_i_nxt));
            end else begin
                r_mem_rd_addr_a <= '0;
                r_mem_rd_addr_b <= '0;
            end

            if (w_state_nxt == S_WRITE) begin
                r_mem_wr_addr <= ADDR_W'(w_dst_nxt + ADDR_W'(w_i_nxt));
                r_mem_wr_data <= w_result_nxt;
            end else begin
                r_mem_wr_addr <= '0;
                r_mem_wr_data <= '0;
            end
        end
    end

    // Aggregate flags: re-armed on acceptance, accumulated per executed element.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err      <= 1'b0;
            r_all_zero <= 1'b0;
            r_any_neg  <= 1'b0;
        end else if (w_accept) begin
            r_err      <= !is_legal_op(cmd_op);
            r_all_zero <= 1'b1;
            r_any_neg  <= 1'b0;
        end else if (r_state == S_EXEC) begin
            r_all_zero <= r_all_zero & alu_zero;
            r_any_neg  <= r_any_neg | alu_negative;
        end
    end

    assign cmd_ready     = r_cmd_ready;
    assign busy          = r_busy;
    assign done          = r_done;
    assign err           = r_err;
    assign all_zero      = r_all_zero;
    assign any_neg       = r_any_neg;
    assign mem_rd_en     = r_mem_rd_en;
    assign mem_rd_addr_a = r_mem_rd_addr_a;
    assign mem_rd_addr_b = r_mem_rd_addr_b;
    assign mem_wr_en     = r_mem_wr_en;
    assign mem_wr_addr   = r_mem_wr_addr;
    assign mem_wr_data   = r_mem_wr_data;
    assign alu_sel       = r_alu_sel;
    assign alu_a         = w_alu_a;
    assign alu_b         = w_alu_b;

endmodule

// File: doc/vec_alu_sequencer.md
Name: vec_alu_sequencer

Overview:
- Sequences the 16-bit scalar ALU over a vector of operand pairs held in the vector data memory, for the encryption datapath's element-wise operations.
- Accepts one vector command: op, two source bases, destination base and length.
- Per element it reads A/B, drives the ALU, captures the result and writes it back.
- Reports completion and aggregate flags. Sits between the decode stage and the ALU/memory.

Parameters:
DATA_W, 16, operand/result width (matches ALU)
ADDR_W, 8, memory word-address width
LEN_W, 5, width of element-count field (max 31 elements)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  sequencer can accept command
cmd_op  in  4  ALU op code (sel encoding)
cmd_src_a  in  ADDR_W  base address, operand A vector
cmd_src_b  in  ADDR_W  base address, operand B vector
cmd_dst  in  ADDR_W  base address, result vector
cmd_len  in  LEN_W  element count
mem_rd_en  out  1  read strobe; data valid next cycle
mem_rd_addr_a  out  ADDR_W  read address A
mem_rd_addr_b  out  ADDR_W  read address B
mem_rd_data_a  in  DATA_W  read data A (1-cycle latency)
mem_rd_data_b  in  DATA_W  read data B
alu_a  out  DATA_W  ALU operand A
alu_b  out  DATA_W  ALU operand B
alu_sel  out  4  ALU select
alu_out  in  DATA_W  ALU result (combinational)
alu_zero  in  1  ALU zero flag
alu_negative  in  1  ALU negative flag
mem_wr_en  out  1  write strobe
mem_wr_addr  out  ADDR_W  write address
mem_wr_data  out  DATA_W  write data
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
err  out  1  valid with done: illegal op
all_zero  out  1  every element result was zero
any_neg  out  1  some element result was negative

Behaviour:
- Interface: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset state: IDLE. Counter i=0.
- Reset output values: cmd_ready=1, busy=0, done=0, err=0, all_zero=0, any_neg=0, mem_rd_en=0, mem_wr_en=0, all addresses/data=0, alu_a=alu_b=0, alu_sel=4'b1100 (stall).
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 LSL are legal with write-back. 5 CMP is legal with flags only and no write. Codes 6-15 are illegal.
- Handshake: command accepted on a clk edge where cmd_valid && cmd_ready. cmd_ready = (state==IDLE). The sequencer latches all cmd fields on acceptance. Acceptance clears all_zero to 1, any_neg to 0 and err to 0.
- FSM states: IDLE, READ, EXEC, WRITE, DONE.
  - IDLE -> READ on accept with legal op and len>0.
  - IDLE -> DONE on accept with len==0 or illegal op. Illegal op sets err=1. No memory or ALU activity occurs.
  - READ: mem_rd_en=1, rd_addr_a=src_a+i, rd_addr_b=src_b+i. Next state EXEC.
  - EXEC: alu_a=mem_rd_data_a, alu_b=mem_rd_data_b, alu_sel=op. Capture alu_out into a result register. all_zero &= alu_zero, any_neg |= alu_negative.
  - EXEC next state: WRITE, or for CMP go directly to the last-element check below.
  - WRITE: mem_wr_en=1, wr_addr=dst+i, wr_data=captured result.
  - Last-element check (after WRITE, or after EXEC for CMP): if i==len-1 go to DONE, else i++ and go to READ.
  - DONE: done=1 for exactly one cycle, busy=0, then IDLE.
- Outside EXEC: alu_a=alu_b=0 and alu_sel=4'b1100.
- busy=1 in READ/EXEC/WRITE.
- Latency, measured in cycles after the accept edge:
  - Write-back op: 3*len cycles of work, done in cycle 3*len+1.
  - CMP: 2*len cycles of work, done in cycle 2*len+1.
  - len==0 or illegal op: done in cycle 1.
- Address arithmetic is modulo 2^ADDR_W (wraps; no error).
- Overlapping src/dst is permitted. Element i is written before element i+1 is read.
- cmd fields that change while busy are ignored.
- Flags all_zero, any_neg and err hold their values until the next acceptance.
- A new command may be accepted the cycle after done (back-to-back allowed).
- rst in any state returns to reset values on that edge. Any write in flight that cycle is suppressed (mem_wr_en=0 after the edge). No done pulse is issued.

Decomposition:
- Package vec_alu_seq_pkg holds:
  - ALU op localparams OP_ADD..OP_STALL (4'b0000..4'b1100).
  - A typedef enum for FSM states.
  - A function is_legal_op(op), and a function op_writes_back(op).
- No sub-module required. The address generator (base+i, wrapping) is inline.

Test Plan:
- ADD, len=3: mem A[0x10..0x12]={5,1,0xFFFF}, B[0x20..0x22]={0xA,2,1}, dst=0x30 -> writes 0x000F, 0x0003, 0x0000 at 0x30..0x32. done in cycle 10. all_zero=0, any_neg=0.
- SUB to zero, len=2: A={0xA,7}, B={0xA,7} -> writes 0,0. all_zero=1.
- CMP, len=2: A={0x000F,1}, B={0x000A,2} -> no mem_wr_en ever asserted. done in cycle 5. any_neg=1.
- Illegal op 4'b0111 with len=4 -> done+err in cycle 1. Zero reads, zero writes. alu_sel stays 4'b1100.
- Wrap, len=2: src_a=0xFF, src_b=0x40, dst=0xFF with OR -> read addresses 0xFF then 0x00. Write addresses 0xFF then 0x00.
- rst asserted during the second element's WRITE (len=4) -> next cycle IDLE, cmd_ready=1, no further writes, no done. A fresh command is then accepted and completes normally.
